// File: rtl/tran_bus_pkg.sv
// Shared types and constants for the A/C bus direction controller.
package tran_bus_pkg;
  typedef enum logic [1:0] {IDLE, OWN_A, TURN, OWN_C} state_t;
  typedef enum logic {SIDE_A, SIDE_C} side_t;

  localparam int TURN_MAX = 15;
  localparam int CW       = $clog2(TURN_MAX + 1);

  // Lone requester wins; on a tie the side that did not own last wins.
  function automatic state_t arb(logic a_req, logic c_req, side_t last);
    if (a_req && c_req) return (last == SIDE_A) ? OWN_C : OWN_A;
    if (a_req)          return OWN_A;
    if (c_req)          return OWN_C;
    return IDLE;
  endfunction
endpackage

// File: rtl/tran_bus_if.sv
// Request/drive/readback bundle between the two bus clients and the controller.
interface tran_bus_if #(parameter int W = 1);
  logic         a_req, c_req, err_clr;
  logic [W-1:0] a_dout, c_dout, a_pin, c_pin;
  logic         a_oe, c_oe, err;
  logic [W-1:0] a_out, c_out;

  modport master (
    input  a_req, c_req, err_clr, a_dout, c_dout, a_pin, c_pin,
    output a_oe, c_oe, err, a_out, c_out
  );
  modport slave (
    output a_req, c_req, err_clr, a_dout, c_dout, a_pin, c_pin,
    input  a_oe, c_oe, err, a_out, c_out
  );
endinterface

// File: rtl/tran_turn_timer.sv
// Load/decrement dead-time counter; done while the count sits at zero.
module tran_turn_timer
  import tran_bus_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          done
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (dec && cnt != '0)     cnt <= cnt - CW'(1);
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/tran_bus_ctrl.sv
// Direction controller for the A/C pass-through switch: arbitration,
// dead-time turnaround, hold-limit preemption and sticky readback check.
module tran_bus_ctrl #(
  parameter int W        = 1,
  parameter int TURN     = 2,   // 1..15
  parameter int MAX_HOLD = 16   // 0 = no preemption
) (
  input  logic       clk,
  input  logic       rst_n,
  tran_bus_if.master bus
);
  import tran_bus_pkg::*;

  // The TURN parameter shadows the enum literal, so alias the state.
  localparam state_t        ST_TURN  = tran_bus_pkg::TURN;
  localparam int            HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [CW-1:0] TURN_LD  = CW'(TURN - 1);

  state_t        state, next;
  side_t         last;
  logic [HW-1:0] hold;
  logic          seasoned, t_done, t_load, owning, other_req, preempt, mismatch;

  assign owning    = (state == OWN_A) || (state == OWN_C);
  assign other_req = (state == OWN_A) ? bus.c_req : bus.a_req;
  assign preempt   = (MAX_HOLD != 0) && (hold == HOLD_LIM) && other_req;
  // First owned cycle still shows the previous value on x_out, so skip it.
  assign mismatch  = seasoned && (((state == OWN_A) && (bus.a_pin != bus.a_out)) ||
                                  ((state == OWN_C) && (bus.c_pin != bus.c_out)));

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = arb(bus.a_req, bus.c_req, last);
      OWN_A:   if (!bus.a_req || preempt) next = ST_TURN;
      ST_TURN: if (t_done) next = arb(bus.a_req, bus.c_req, last);
      OWN_C:   if (!bus.c_req || preempt) next = ST_TURN;
      default: next = IDLE;
    endcase
  end

  assign t_load = (next == ST_TURN) && (state != ST_TURN);

  tran_turn_timer u_turn (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (TURN_LD),
    .dec      (state == ST_TURN),
    .done     (t_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= SIDE_C;
      hold      <= '0;
      seasoned  <= 1'b0;
      bus.a_oe  <= 1'b0;
      bus.c_oe  <= 1'b0;
      bus.a_out <= '0;
      bus.c_out <= '0;
      bus.err   <= 1'b0;
    end else begin
      state    <= next;
      bus.a_oe <= (next == OWN_A);
      bus.c_oe <= (next == OWN_C);
      if (next != state && next == OWN_A) last <= SIDE_A;
      if (next != state && next == OWN_C) last <= SIDE_C;
      if (next != state)
        hold <= '0;
      else if (owning && other_req && hold != HOLD_LIM)
        hold <= hold + HW'(1);
      seasoned <= owning && (next == state);
      if (state == OWN_A) bus.a_out <= bus.a_dout;
      if (state == OWN_C) bus.c_out <= bus.c_dout;
      if (mismatch)         bus.err <= 1'b1;
      else if (bus.err_clr) bus.err <= 1'b0;
    end
  end
endmodule
